// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: registered N-port arbiter producing a one-hot grant plus
// its binary index. Round-robin or fixed priority, with an optional hold of
// the grant until acknowledge (or until the granted request drops).
//
// Ports:
//   clk            rising-edge clock
//   rst_l          asynchronous, active-low reset
//   request        per-port level request               [PORTS]
//   acknowledge    per-port completion pulse; only the bit at grant_encoded
//                  is looked at, and only while a grant is held  [PORTS]
//   grant          registered one-hot grant              [PORTS]
//   grant_valid    registered |grant
//   grant_encoded  registered index of the granted port  [$clog2(PORTS)]

// Priority encoder: reports the highest-priority set bit of 'in'.
module arb_prio_enc #(
    parameter int WIDTH             = 4,
    parameter int LSB_HIGH_PRIORITY = 1,
    parameter int IW                = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in,
    output logic             valid,
    output logic [IW-1:0]    idx,
    output logic [WIDTH-1:0] onehot
);
    // The last matching bit in scan order wins, so scan from the
    // lowest-priority end towards the highest-priority end.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        if (LSB_HIGH_PRIORITY != 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in[i]) begin
                    valid = 1'b1;
                    idx   = IW'(i);
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in[i]) begin
                    valid = 1'b1;
                    idx   = IW'(i);
                end
            end
        end
        if (valid)
            onehot = WIDTH'(1) << idx;
    end
endmodule

module axi_rr_arbiter #(
    parameter int PORTS             = 4,
    parameter int ARB_ROUND_ROBIN   = 1,
    parameter int ARB_BLOCK         = 1,
    parameter int ARB_BLOCK_ACK     = 1,
    parameter int LSB_HIGH_PRIORITY = 1
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic [PORTS-1:0]         request,
    input  logic [PORTS-1:0]         acknowledge,
    output logic [PORTS-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(PORTS)-1:0] grant_encoded
);
    localparam int IW = $clog2(PORTS);

    logic [PORTS-1:0] mask;
    logic [PORTS-1:0] masked_req;
    logic [PORTS-1:0] req_oh, msk_oh, win_oh, next_mask;
    logic [IW-1:0]    req_idx, msk_idx, win_idx;
    logic             req_v, msk_v, win_v;
    logic             free;

    assign masked_req = request & mask;

    arb_prio_enc #(.WIDTH(PORTS), .LSB_HIGH_PRIORITY(LSB_HIGH_PRIORITY), .IW(IW)) u_enc_req (
        .in     (request),
        .valid  (req_v),
        .idx    (req_idx),
        .onehot (req_oh)
    );

    arb_prio_enc #(.WIDTH(PORTS), .LSB_HIGH_PRIORITY(LSB_HIGH_PRIORITY), .IW(IW)) u_enc_msk (
        .in     (masked_req),
        .valid  (msk_v),
        .idx    (msk_idx),
        .onehot (msk_oh)
    );

    // A masked requester (strictly lower priority than the last winner)
    // takes precedence; otherwise wrap around to the raw requests.
    always_comb begin
        win_v   = req_v;
        win_idx = req_idx;
        win_oh  = req_oh;
        if (ARB_ROUND_ROBIN != 0 && msk_v) begin
            win_idx = msk_idx;
            win_oh  = msk_oh;
        end
    end

    // Ports ranked strictly below the winner become next round's mask.
    always_comb begin
        if (LSB_HIGH_PRIORITY != 0)
            next_mask = ~(win_oh | (win_oh - PORTS'(1)));
        else
            next_mask = win_oh - PORTS'(1);
    end

    // Release and re-arbitrate in the same cycle, so grants run back-to-back.
    always_comb begin
        free = 1'b1;
        if (ARB_BLOCK != 0 && grant_valid) begin
            if (ARB_BLOCK_ACK != 0)
                free = acknowledge[grant_encoded];
            else
                free = ~request[grant_encoded];
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            grant         <= '0;
            grant_valid   <= 1'b0;
            grant_encoded <= '0;
            mask          <= '0;
        end else if (free) begin
            grant         <= win_oh;
            grant_valid   <= win_v;
            grant_encoded <= win_idx;
            if (ARB_ROUND_ROBIN != 0 && win_v)
                mask <= next_mask;
        end
    end
endmodule
